eth_rx_framer: RTL and testbench
================================

ETH_RX_FRAMER -- requirements
Module: eth_rx_framer

Interface
REQ-001 Parameter BUF_WORDS, default 256: RX buffer depth in 64-bit words.
REQ-002 Parameter MAX_LEN, default 1536: max stored frame bytes, FCS included.
REQ-003 Parameter ADDR_W, default 8: buffer word address width, equal to clog2(BUF_WORDS).
REQ-004 clk_i  in  1  single clock; all ports are synchronous to it.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 rx_dv_i  in  1  receive data valid (GMII-style byte stream).
REQ-007 rx_er_i  in  1  receive error.
REQ-008 rxd_i  in  8  receive byte.
REQ-009 buf_we_o  out  1  RX buffer word write strobe.
REQ-010 buf_addr_o  out  ADDR_W  word address.
REQ-011 buf_data_o  out  64  write data; byte n of the frame is on lane n%8, little-endian.
REQ-012 buf_be_o  out  8  byte enables.
REQ-013 frame_valid_o  out  1  completed frame pending.
REQ-014 frame_len_o  out  16  byte count after SFD, FCS included.
REQ-015 frame_err_o  out  1  frame is runt, oversize or rx_er.
REQ-016 crc_ok_o  out  1  FCS check passed.
REQ-017 frame_ack_i  in  1  software releases the pending frame.
REQ-018 drop_cnt_o  out  8  saturating count of discarded frames.

Function
REQ-019 FSM states are IDLE, PREAMBLE, DATA, HOLD and DROP.
REQ-020 IDLE transitions:
- rx_dv_i=1 and rxd_i=0x55 -> PREAMBLE.
- rx_dv_i=1 with any other byte -> DROP.
REQ-021 PREAMBLE transitions:
- 0x55 -> stay.
- 0xD5 -> DATA; byte count, lane and word address cleared.
- rx_dv_i=0 -> IDLE.
- any other byte -> DROP.
REQ-022 In DATA, each cycle with rx_dv_i=1 places rxd_i in lane count%8 and increments the byte count.
REQ-023 A full word is written on the cycle after its lane-7 byte is sampled: buf_we_o=1, buf_be_o=0xFF, buf_addr_o=count/8.
REQ-024 When rx_dv_i is first sampled 0 in DATA, a partially filled word is flushed on the next cycle with buf_be_o enabling only the filled lanes.
- No flush occurs when count%8=0.
REQ-025 frame_valid_o rises exactly 2 cycles after rx_dv_i is first sampled 0 in DATA, and the FSM enters HOLD.
REQ-026 frame_len_o, frame_err_o and crc_ok_o are stable while frame_valid_o=1.
REQ-027 rx_er_i=1 in any DATA cycle sets frame_err_o; reception continues to the end of the frame.
REQ-028 A byte count below 64 at end of frame sets frame_err_o (runt).
REQ-029 A byte count beyond MAX_LEN sets frame_err_o.
- All writes stop for the rest of the frame.
- The count keeps incrementing.
- frame_len_o saturates at 0xFFFF.
REQ-030 buf_addr_o never wraps; MAX_LEN/8 shall not exceed BUF_WORDS.
REQ-031 HOLD: frame_valid_o stays 1 until frame_ack_i is sampled 1; it then clears on the next cycle and the FSM returns to IDLE.
REQ-032 A frame whose rx_dv_i rises during HOLD is never written; drop_cnt_o increments once for it.
REQ-033 After the ack, a frame already in progress is tracked through DROP and not stored.
REQ-034 DROP: no writes; wait until rx_dv_i=0, then IDLE; drop_cnt_o increments once, saturating at 255.
REQ-035 frame_ack_i outside HOLD has no effect.

Reset
REQ-036 rst_ni low asynchronously forces IDLE and sets every output to 0:
- buf_we_o, buf_addr_o, buf_data_o, buf_be_o;
- frame_valid_o, frame_len_o, frame_err_o;
- crc_ok_o (0 under reset only);
- drop_cnt_o.
REQ-037 Reset mid-frame abandons the frame without any write; after release, bytes continue to be discarded until rx_dv_i=0 is seen.

Configuration
REQ-038 Macro ETH_RX_FRAMER_CRC_CHECK_EN selects FCS checking.
REQ-039 With the macro defined:
- CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected) runs over every DATA byte, FCS included.
- crc_ok_o=1 iff the final residue equals 0xC704DD7B.
- crc_ok_o=0 does not set frame_err_o.
REQ-040 With the macro undefined, no CRC logic is present and crc_ok_o is tied to 1 outside reset.

Verification
REQ-041 Preamble x7, SFD, 60 bytes 0x00..0x3B, valid FCS ->
- 8 writes at addresses 0..7, all buf_be_o=0xFF;
- frame_len_o=64, frame_err_o=0, crc_ok_o=1 (CRC on).
REQ-042 67-byte frame -> last write at address 8 with buf_be_o=0x07; frame_valid_o rises 2 cycles after rx_dv_i falls.
REQ-043 64-byte frame with rx_er_i at byte 10, and a separate 40-byte frame -> each has frame_err_o=1, with frame_len_o=64 and 40 respectively.
REQ-044 Second frame arrives during HOLD, ack after it ends -> no buf_we_o; drop_cnt_o=1; first frame's outputs unchanged.
REQ-045 rst_ni pulsed at byte 20 of a frame -> outputs 0 immediately; no writes for the remainder; next frame stored from address 0.
REQ-046 Corrupted FCS -> crc_ok_o=0 and frame_err_o=0 with the macro defined; crc_ok_o=1 without it.

Source files
------------

// File: rtl/eth_rx_framer.sv
// eth_rx_framer: GMII-style receive framer that strips preamble/SFD and writes frames into a 64-bit word buffer.
// Define ETH_RX_FRAMER_CRC_CHECK_EN to enable FCS (CRC-32) checking; otherwise crc_ok_o is tied high.
module eth_rx_framer #(
  parameter int unsigned BUF_WORDS = 256,
  parameter int unsigned MAX_LEN   = 1536,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_dv_i,
  input  logic              rx_er_i,
  input  logic [7:0]        rxd_i,
  output logic              buf_we_o,
  output logic [ADDR_W-1:0] buf_addr_o,
  output logic [63:0]       buf_data_o,
  output logic [7:0]        buf_be_o,
  output logic              frame_valid_o,
  output logic [15:0]       frame_len_o,
  output logic              frame_err_o,
  output logic              crc_ok_o,
  input  logic              frame_ack_i,
  output logic [7:0]        drop_cnt_o
);

  localparam int unsigned MIN_LEN  = 64;
  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, HOLD, DROP} state_t;

  state_t              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [63:0]         word_q, word_d;
  logic                er_q, er_d;
  logic                sync_q, sync_d;
  logic                dv_q, dv_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [63:0]         data_q, data_d;
  logic [7:0]          be_q, be_d;
  logic                valid_q, valid_d;
  logic [15:0]         len_q, len_d;
  logic                err_q, err_d;
  logic                crc_ok_q, crc_ok_d;
  logic [7:0]          drop_q, drop_d;
  logic                drop_inc;
  logic [2:0]          lane;
  logic                crc_match_c;

`ifdef ETH_RX_FRAMER_CRC_CHECK_EN
  localparam bit          CRC_EN        = 1'b1;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY_REFL) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [31:0] bit_rev32(input logic [31:0] c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = c[31-i];
    end
    return r;
  endfunction

  // LSB-first CRC over every DATA byte, seeded on the SFD
  always_comb begin
    crc_d = crc_q;
    if (state_q == PREAMBLE && rx_dv_i && rxd_i == SFD_BYTE) begin
      crc_d = '1;
    end else if (state_q == DATA && rx_dv_i) begin
      crc_d = crc_byte(crc_q, rxd_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) crc_q <= '1;
    else         crc_q <= crc_d;
  end

  assign crc_match_c = (bit_rev32(crc_q) == CRC_RESIDUE);
`else
  localparam bit CRC_EN = 1'b0;
  assign crc_match_c = 1'b1;
`endif

  assign lane = count_q[2:0];

  // next-state, buffer write and frame status logic
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    word_d   = word_q;
    er_d     = er_q;
    sync_d   = sync_q | ~rx_dv_i;
    dv_d     = rx_dv_i;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    be_d     = be_q;
    valid_d  = valid_q;
    len_d    = len_q;
    err_d    = err_q;
    crc_ok_d = CRC_EN ? crc_ok_q : 1'b1;
    drop_inc = 1'b0;

    case (state_q)
      IDLE: begin
        // after reset, a frame already on the wire is ignored until the line goes idle
        if (rx_dv_i && sync_q) begin
          state_d = (rxd_i == PRE_BYTE) ? PREAMBLE : DROP;
        end
      end
      PREAMBLE: begin
        if (!rx_dv_i) begin
          state_d = IDLE;
        end else if (rxd_i == SFD_BYTE) begin
          state_d = DATA;
          count_d = '0;
          word_d  = '0;
          er_d    = 1'b0;
        end else if (rxd_i != PRE_BYTE) begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (rx_dv_i) begin
          word_d[{lane, 3'b000} +: 8] = rxd_i;
          if (rx_er_i) er_d = 1'b1;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          if (lane == 3'd7) begin
            if (32'(count_q) < MAX_LEN && 32'(count_q >> 3) < BUF_WORDS) begin
              we_d   = 1'b1;
              addr_d = ADDR_W'(count_q >> 3);
              data_d = word_d;
              be_d   = 8'hFF;
            end
            word_d = '0;
          end
        end else begin
          if (lane != 3'd0 && 32'(count_q) <= MAX_LEN && 32'(count_q >> 3) < BUF_WORDS) begin
            we_d   = 1'b1;
            addr_d = ADDR_W'(count_q >> 3);
            data_d = word_q;
            be_d   = ~(8'hFF << lane);
          end
          word_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // a frame that starts and ends while holding is counted as dropped here
        if (dv_q && !rx_dv_i) drop_inc = 1'b1;
        if (!valid_q) begin
          valid_d  = 1'b1;
          len_d    = count_q;
          err_d    = er_q || (32'(count_q) < MIN_LEN) || (32'(count_q) > MAX_LEN);
          crc_ok_d = crc_match_c;
        end else if (frame_ack_i) begin
          valid_d = 1'b0;
          state_d = rx_dv_i ? DROP : IDLE;
        end
      end
      DROP: begin
        if (!rx_dv_i) begin
          state_d  = IDLE;
          drop_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    drop_d = (drop_inc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      count_q  <= '0;
      word_q   <= '0;
      er_q     <= 1'b0;
      sync_q   <= 1'b0;
      dv_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      be_q     <= '0;
      valid_q  <= 1'b0;
      len_q    <= '0;
      err_q    <= 1'b0;
      crc_ok_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      word_q   <= word_d;
      er_q     <= er_d;
      sync_q   <= sync_d;
      dv_q     <= dv_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      be_q     <= be_d;
      valid_q  <= valid_d;
      len_q    <= len_d;
      err_q    <= err_d;
      crc_ok_q <= crc_ok_d;
      drop_q   <= drop_d;
    end
  end

  assign buf_we_o      = we_q;
  assign buf_addr_o    = addr_q;
  assign buf_data_o    = data_q;
  assign buf_be_o      = be_q;
  assign frame_valid_o = valid_q;
  assign frame_len_o   = len_q;
  assign frame_err_o   = err_q;
  assign crc_ok_o      = crc_ok_q;
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_eth_rx_framer.sv
// tb_eth_rx_framer: directed and randomized frames for eth_rx_framer, checked against a byte-level frame model.
// Expected crc_ok_o follows ETH_RX_FRAMER_CRC_CHECK_EN the same way the design does.
module tb_eth_rx_framer;

  localparam int unsigned BUF_WORDS = 256;
  localparam int unsigned MAX_LEN   = 1536;
  localparam int unsigned ADDR_W    = 8;

  logic              clk_i       = 1'b0;
  logic              rst_ni      = 1'b0;
  logic              rx_dv_i     = 1'b0;
  logic              rx_er_i     = 1'b0;
  logic [7:0]        rxd_i       = 8'h00;
  logic              frame_ack_i = 1'b0;
  logic              buf_we_o;
  logic [ADDR_W-1:0] buf_addr_o;
  logic [63:0]       buf_data_o;
  logic [7:0]        buf_be_o;
  logic              frame_valid_o;
  logic [15:0]       frame_len_o;
  logic              frame_err_o;
  logic              crc_ok_o;
  logic [7:0]        drop_cnt_o;

  eth_rx_framer #(.BUF_WORDS(BUF_WORDS), .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_dv_i(rx_dv_i), .rx_er_i(rx_er_i), .rxd_i(rxd_i),
    .buf_we_o(buf_we_o), .buf_addr_o(buf_addr_o), .buf_data_o(buf_data_o), .buf_be_o(buf_be_o),
    .frame_valid_o(frame_valid_o), .frame_len_o(frame_len_o), .frame_err_o(frame_err_o),
    .crc_ok_o(crc_ok_o), .frame_ack_i(frame_ack_i), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rise_cyc = -1;
  int end_cyc  = 0;
  int drop_exp = 0;
  logic valid_prev = 1'b0;

  logic [7:0]        fr_q[$];
  logic [ADDR_W-1:0] wa_q[$];
  logic [63:0]       wd_q[$];
  logic [7:0]        wb_q[$];
  logic [15:0]       exp_len;
  logic              exp_err;
  logic              exp_crc;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // capture buffer writes and the cycle at which frame_valid_o rises
  always @(posedge clk_i) begin
    cyc++;
    #2;
    if (buf_we_o === 1'b1) begin
      wa_q.push_back(buf_addr_o);
      wd_q.push_back(buf_data_o);
      wb_q.push_back(buf_be_o);
    end
    if (frame_valid_o === 1'b1 && !valid_prev) rise_cyc = cyc;
    valid_prev = frame_valid_o;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, fr_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input int payload, input bit rnd);
    logic [31:0] f;
    fr_q.delete();
    for (int i = 0; i < payload; i++) fr_q.push_back(rnd ? 8'($urandom) : 8'(i));
    f = fcs_of(payload);
    for (int b = 0; b < 4; b++) fr_q.push_back(f[8*b +: 8]);
  endtask

  task automatic step(input logic dv, input logic er, input logic [7:0] d);
    @(posedge clk_i);
    #1;
    rx_dv_i = dv;
    rx_er_i = er;
    rxd_i   = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int er_at, input bit mid_ack);
    wa_q.delete(); wd_q.delete(); wb_q.delete();
    rise_cyc = -1;
    repeat (7) step(1'b1, 1'b0, 8'h55);
    step(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < fr_q.size(); i++) begin
      step(1'b1, i == er_at, fr_q[i]);
      frame_ack_i = mid_ack && (i == 5);
    end
    step(1'b0, 1'b0, 8'h00);
    frame_ack_i = 1'b0;
    end_cyc = cyc;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (frame_valid_o !== 1'b1 && n < 16) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    #2;
    check("valid_seen", 64'(frame_valid_o), 64'd1);
    check("valid_latency", 64'(rise_cyc - end_cyc), 64'd2);
  endtask

  task automatic do_ack(input int delay);
    idle(delay);
    @(posedge clk_i); #1; frame_ack_i = 1'b1;
    @(posedge clk_i); #1; frame_ack_i = 1'b0;
    check("valid_clear", 64'(frame_valid_o), 64'd0);
  endtask

  // reference: status from the received byte list
  task automatic expect_frame(input bit er_flag);
    int n;
    n = fr_q.size();
    exp_len = (n > 65535) ? 16'hFFFF : 16'(n);
    exp_err = er_flag || (n < 64) || (n > int'(MAX_LEN));
`ifdef ETH_RX_FRAMER_CRC_CHECK_EN
    exp_crc = (n >= 4) && (fcs_of(n - 4) == {fr_q[n-1], fr_q[n-2], fr_q[n-3], fr_q[n-4]});
`else
    exp_crc = 1'b1;
`endif
  endtask

  task automatic check_outputs();
    check("frame_len", 64'(frame_len_o), 64'(exp_len));
    check("frame_err", 64'(frame_err_o), 64'(exp_err));
    check("crc_ok", 64'(crc_ok_o), 64'(exp_crc));
  endtask

  task automatic check_writes();
    int n, nw, idx;
    logic [7:0]  be;
    logic [63:0] dat, msk;
    n  = fr_q.size();
    nw = (n > int'(MAX_LEN)) ? int'(MAX_LEN) / 8 : (n + 7) / 8;
    check("n_writes", 64'(wa_q.size()), 64'(nw));
    for (int w = 0; w < nw && w < int'(wa_q.size()); w++) begin
      be = '0; dat = '0; msk = '0;
      for (int l = 0; l < 8; l++) begin
        idx = w * 8 + l;
        if (idx < n) begin
          be[l] = 1'b1;
          dat[l*8 +: 8] = fr_q[idx];
          msk[l*8 +: 8] = 8'hFF;
        end
      end
      check("wr_addr", 64'(wa_q[w]), 64'(w));
      check("wr_be", 64'(wb_q[w]), 64'(be));
      check("wr_data", wd_q[w] & msk, dat);
    end
  endtask

  task automatic check_frame(input bit er_flag);
    expect_frame(er_flag);
    check_outputs();
    check_writes();
  endtask

  int er_at;
  int pay;
  int idx;

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_data", buf_data_o, 64'd0);
    check("rst_ctl", 64'({buf_we_o, buf_addr_o, buf_be_o, frame_valid_o, frame_len_o,
                          frame_err_o, crc_ok_o, drop_cnt_o}), 64'd0);
    rst_ni = 1'b1;
    idle(3);

    // 60 incrementing bytes plus FCS
    build_frame(60, 1'b0);
    send_frame(-1, 1'b0); wait_valid(); check_frame(1'b0); do_ack(2); idle(2);

    // 67 bytes: partial last word; stray ack while receiving
    build_frame(63, 1'b1);
    send_frame(-1, 1'b1); wait_valid(); check_frame(1'b0); do_ack(1); idle(2);

    // rx_er at byte 10
    build_frame(60, 1'b1);
    send_frame(10, 1'b0); wait_valid(); check_frame(1'b1); do_ack(0); idle(2);

    // runt
    build_frame(36, 1'b1);
    send_frame(-1, 1'b0); wait_valid(); check_frame(1'b0); do_ack(3); idle(2);

    // corrupted FCS
    build_frame(60, 1'b1);
    fr_q[62] = fr_q[62] ^ 8'h01;
    send_frame(-1, 1'b0); wait_valid(); check_frame(1'b0); do_ack(1); idle(2);

    // oversize
    build_frame(1536, 1'b1);
    send_frame(-1, 1'b0); wait_valid(); check_frame(1'b0); do_ack(1); idle(2);

    // frame arriving and ending during HOLD is dropped; held status unchanged
    build_frame(60, 1'b1);
    send_frame(-1, 1'b0); wait_valid(); check_frame(1'b0);
    build_frame(40, 1'b1);
    send_frame(-1, 1'b0); idle(3);
    drop_exp++;
    check("hold_writes", 64'(wa_q.size()), 64'd0);
    check("hold_drop_cnt", 64'(drop_cnt_o), 64'(drop_exp));
    check("hold_valid", 64'(frame_valid_o), 64'd1);
    check_outputs();
    do_ack(1); idle(2);

    // ack while a frame is in progress: tail is dropped, not stored
    build_frame(60, 1'b1);
    send_frame(-1, 1'b0); wait_valid(); check_frame(1'b0);
    build_frame(40, 1'b1);
    send_frame(-1, 1'b1); idle(3);
    drop_exp++;
    check("ackmid_writes", 64'(wa_q.size()), 64'd0);
    check("ackmid_drop_cnt", 64'(drop_cnt_o), 64'(drop_exp));
    check("ackmid_valid", 64'(frame_valid_o), 64'd0);
    idle(2);

    // reset at byte 20: outputs clear at once, the rest of the frame is ignored
    build_frame(60, 1'b1);
    repeat (7) step(1'b1, 1'b0, 8'h55);
    step(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, fr_q[i]);
    step(1'b1, 1'b0, fr_q[20]);
    rst_ni = 1'b0;
    #1;
    check("rstmid_data", buf_data_o, 64'd0);
    check("rstmid_ctl", 64'({buf_we_o, buf_addr_o, buf_be_o, frame_valid_o, frame_len_o,
                             frame_err_o, crc_ok_o, drop_cnt_o}), 64'd0);
    step(1'b1, 1'b0, fr_q[21]);
    rst_ni = 1'b1;
    wa_q.delete(); wd_q.delete(); wb_q.delete();
    for (int i = 22; i < fr_q.size(); i++) step(1'b1, 1'b0, fr_q[i]);
    idle(4);
    check("rstmid_writes", 64'(wa_q.size()), 64'd0);
    check("rstmid_valid", 64'(frame_valid_o), 64'd0);
    build_frame(60, 1'b1);
    send_frame(-1, 1'b0); wait_valid(); check_frame(1'b0); do_ack(1); idle(2);

    // randomized frames
    for (int k = 0; k < 20; k++) begin
      pay = int'($urandom_range(0, 120)) + 36;
      build_frame(pay, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        idx = int'($urandom_range(0, 3)) + pay;
        fr_q[idx] = fr_q[idx] ^ 8'(1 << $urandom_range(0, 7));
      end
      er_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 200)) : -1;
      if (er_at >= int'(fr_q.size())) er_at = -1;
      send_frame(er_at, 1'($urandom_range(0, 1)));
      wait_valid();
      check_frame(er_at >= 0);
      do_ack(int'($urandom_range(0, 4)));
      idle(int'($urandom_range(1, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
